// File: rtl/instr_cache_fill.sv
// instr_cache_fill: line-fill engine on the memory side of the direct-mapped I-cache.
// On a miss it issues one block read, then gathers BLOCK_WIDTH/BEAT_WIDTH response
// beats into a line. It writes that line to the cache with a one-cycle pulse.
// Optional feature: define FILL_TIMEOUT_EN to enable the idle-beat watchdog.
// The watchdog aborts the fill with o_fill_err after TIMEOUT_CYCLES silent RECV cycles.
module instr_cache_fill #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned BLOCK_WIDTH    = 512,
    parameter int unsigned BEAT_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_miss,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_busy,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_rsp_valid,
    input  logic [BEAT_WIDTH-1:0]  i_mem_rsp_data,
    output logic                   o_mem_rsp_ready,
    output logic                   o_cache_we,
    output logic [ADDR_WIDTH-1:0]  o_cache_addr,
    output logic [BLOCK_WIDTH-1:0] o_cache_line,
    output logic                   o_fill_done,
    output logic                   o_fill_err
);

    localparam int unsigned BEATS = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((BLOCK_WIDTH % BEAT_WIDTH) != 0 || BEATS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("instr_cache_fill: BLOCK_WIDTH must be a nonzero multiple of BEAT_WIDTH and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      beat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  beat_fire;
    logic                  wd_expire;

    // A beat is taken only while the engine advertises ready, i.e. in RECV.
    assign beat_fire    = o_mem_rsp_ready && i_mem_rsp_valid;
    assign o_cache_addr = addr_q;
    assign o_mem_addr   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

`ifdef FILL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    // Fires on the edge where the silent-cycle count reaches TIMEOUT_CYCLES.
    assign wd_expire = (state_q == S_RECV) && !beat_fire &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts consecutive RECV cycles without an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q != S_RECV || beat_fire || wd_expire) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Fill FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            beat_q          <= '0;
            addr_q          <= '0;
            o_busy          <= 1'b0;
            o_mem_req_valid <= 1'b0;
            o_mem_rsp_ready <= 1'b0;
            o_cache_we      <= 1'b0;
            o_cache_line    <= '0;
            o_fill_done     <= 1'b0;
            o_fill_err      <= 1'b0;
        end else begin
            o_cache_we  <= 1'b0;
            o_fill_done <= 1'b0;
            o_fill_err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_miss) begin
                        addr_q          <= i_miss_addr;
                        o_busy          <= 1'b1;
                        o_mem_req_valid <= 1'b1;
                        state_q         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        o_mem_rsp_ready <= 1'b1;
                        state_q         <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (wd_expire) begin
                        beat_q          <= '0;
                        o_cache_line    <= '0;
                        o_mem_rsp_ready <= 1'b0;
                        o_busy          <= 1'b0;
                        o_fill_err      <= 1'b1;
                        state_q         <= S_IDLE;
                    end else if (beat_fire) begin
                        o_cache_line[32'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] <= i_mem_rsp_data;
                        if (beat_q == LAST_BEAT) begin
                            beat_q          <= '0;
                            o_mem_rsp_ready <= 1'b0;
                            o_cache_we      <= 1'b1;
                            o_fill_done     <= 1'b1;
                            state_q         <= S_WRITE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
